// File: rtl/toycpu_pkg.sv
// Shared constants for the toycpu MMIO UART transmitter: register offsets, bit positions, TX states.
// TOYCPU_UART_PARITY_EN adds the PARITY state to the TX state enum.
package toycpu_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_LVL_LSB   = 4;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int CTRL_CLR_OVF_BIT = 2;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
`ifdef TOYCPU_UART_PARITY_EN
    , TX_PARITY = 3'd4
`endif
  } tx_state_t;

endpackage

// File: rtl/toycpu_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop happens on the same edge.
module toycpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/toycpu_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the toycpu data bus (4-word register window, byte FIFO).
// TOYCPU_UART_PARITY_EN inserts an even-parity bit between DATA and STOP.
//
// state  | meaning
// IDLE   | line high, waiting for enable and a queued byte
// START  | start bit (low) for one bit period
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the byte (only with TOYCPU_UART_PARITY_EN)
// STOP   | stop bit (high); may chain directly into the next START
module toycpu_mmio_uart_tx
  import toycpu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic        mem_sel,
  output logic [15:0] mem_rdata,
  output logic        tx,
  output logic        tx_busy
);
  localparam int              BW          = $clog2(CLKS_PER_BIT);
  localparam int              LW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]   BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    reg_off;
  logic          bus_wr, data_wr, ctrl_wr, flush_w;
  logic          enable_q, enable_d, ovf_q, ovf_d;
  logic          fifo_full, fifo_empty, can_pop, pop_now;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] fifo_level;
  logic [15:0]   lvl_ext, status_w;
  logic [3:0]    lvl_sat;
  logic          unused_wdata;

  tx_state_t     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
`ifdef TOYCPU_UART_PARITY_EN
  logic          parity_q;
`endif

  assign mem_sel = ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, mem_addr} <= ({1'b0, BASE_ADDR} + 17'd3));
  assign reg_off = mem_addr[1:0] - BASE_ADDR[1:0];
  assign bus_wr  = mem_we && mem_sel;
  assign data_wr = bus_wr && (reg_off == REG_DATA);
  assign ctrl_wr = bus_wr && (reg_off == REG_CTRL);
  assign flush_w = ctrl_wr && mem_wdata[CTRL_FLUSH_BIT];
  assign unused_wdata = ^mem_wdata[15:8];

  // A flush on this edge must not also hand a byte to the shifter.
  assign can_pop = enable_q && !fifo_empty && !flush_w;
  assign pop_now = can_pop && ((state_q == TX_IDLE) ||
                               ((state_q == TX_STOP) && (baud_q == '0)));

  toycpu_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (pop_now),
    .flush (flush_w),
    .din   (mem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    enable_d = enable_q;
    ovf_d    = ovf_q;
    if (ctrl_wr) enable_d = mem_wdata[CTRL_EN_BIT];
    if (data_wr && fifo_full && !pop_now) ovf_d = 1'b1;
    if (ctrl_wr && mem_wdata[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef TOYCPU_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (pop_now) begin
            state_q <= TX_START;
            tx_q    <= 1'b0;
            baud_q  <= BAUD_RELOAD;
            shift_q <= fifo_dout;
`ifdef TOYCPU_UART_PARITY_EN
            parity_q <= ^fifo_dout;
`endif
          end
        end
        TX_START: begin
          if (baud_q == '0) begin
            state_q <= TX_DATA;
            tx_q    <= shift_q[0];
            baud_q  <= BAUD_RELOAD;
            bit_q   <= '0;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_RELOAD;
            if (bit_q == 3'd7) begin
`ifdef TOYCPU_UART_PARITY_EN
              state_q <= TX_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`ifdef TOYCPU_UART_PARITY_EN
        TX_PARITY: begin
          if (baud_q == '0) begin
            state_q <= TX_STOP;
            tx_q    <= 1'b1;
            baud_q  <= BAUD_RELOAD;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`endif
        TX_STOP: begin
          if (baud_q == '0) begin
            if (pop_now) begin
              state_q <= TX_START;
              tx_q    <= 1'b0;
              baud_q  <= BAUD_RELOAD;
              shift_q <= fifo_dout;
`ifdef TOYCPU_UART_PARITY_EN
              parity_q <= ^fifo_dout;
`endif
            end else begin
              state_q <= TX_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != TX_IDLE);

  assign lvl_ext = 16'(fifo_level);
  assign lvl_sat = (lvl_ext > 16'd15) ? 4'hF : lvl_ext[3:0];

  always_comb begin
    status_w = '0;
    status_w[STAT_FULL_BIT]  = fifo_full;
    status_w[STAT_EMPTY_BIT] = fifo_empty;
    status_w[STAT_BUSY_BIT]  = tx_busy;
    status_w[STAT_OVF_BIT]   = ovf_q;
    status_w[STAT_LVL_LSB +: 4] = lvl_sat;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_sel) begin
      case (reg_off)
        REG_STATUS: mem_rdata = status_w;
        REG_CTRL:   mem_rdata = {15'b0, enable_q};
        REG_DATA, REG_RSVD: mem_rdata = '0;
        default:    mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_toycpu_mmio_uart_tx.sv
// Directed bench for toycpu_mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8); honours TOYCPU_UART_PARITY_EN.
module tb_toycpu_mmio_uart_tx;
  localparam int C = 4;
`ifdef TOYCPU_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam logic [15:0] A_DATA = 16'hFF00, A_STAT = 16'hFF01, A_CTRL = 16'hFF02, A_RSVD = 16'hFF03;

  logic        clk = 1'b0, rst = 1'b0, mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0000, mem_wdata = 16'h0000;
  logic        mem_sel, tx, tx_busy;
  logic [15:0] mem_rdata;

  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] bytes [16];

  toycpu_mmio_uart_tx #(.BASE_ADDR(16'hFF00), .CLKS_PER_BIT(C), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a negedge; the store lands on the following posedge.
  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    mem_addr = addr; mem_wdata = data; mem_we = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    mem_addr = addr; mem_we = 1'b0;
    #1;
    check(tag, mem_rdata, exp);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef TOYCPU_UART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at the negedge right after the edge that makes a byte poppable.
  task automatic expect_stream(input string tag, input int n);
    check({tag, "_pre_tx"}, 16'(tx), 16'h1);
    @(posedge clk); #1;
    check({tag, "_start_tx"}, 16'(tx), 16'h0);
    check({tag, "_start_busy"}, 16'(tx_busy), 16'h1);
    @(negedge clk); @(negedge clk);
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < NB; i++) begin
        check($sformatf("%s_f%0d_b%0d", tag, f, i), 16'(tx), 16'(exp_bit(bytes[f], i)));
        repeat (C) @(negedge clk);
      end
    end
    check({tag, "_end_busy"}, 16'(tx_busy), 16'h0);
    check({tag, "_end_tx"}, 16'(tx), 16'h1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (!tx || tx_busy) bad++;
    end
    check(tag, 16'(bad), 16'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", 16'(tx), 16'h1);
    check("rst_busy", 16'(tx_busy), 16'h0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_tx", 16'(tx), 16'h1);
    check("idle_busy", 16'(tx_busy), 16'h0);
    bus_read("idle_status", A_STAT, 16'h0002);
    bus_read("idle_ctrl", A_CTRL, 16'h0001);
    bus_read("data_reads0", A_DATA, 16'h0000);
    bus_read("rsvd_reads0", A_RSVD, 16'h0000);
    check("sel_in_window", 16'(mem_sel), 16'h1);
    bus_read("below_window", 16'hFEFF, 16'h0000);
    check("sel_below", 16'(mem_sel), 16'h0);
    bus_read("above_window", 16'hFF04, 16'h0000);
    check("sel_above", 16'(mem_sel), 16'h0);
    @(negedge clk);
    bus_write(A_RSVD, 16'hFFFF);
    bus_write(16'hFF04, 16'h00AA);
    bus_read("rsvd_wr_ctrl", A_CTRL, 16'h0001);
    bus_read("rsvd_wr_status", A_STAT, 16'h0002);

    // Single frame 0xA5.
    @(negedge clk);
    bytes[0] = 8'hA5;
    bus_write(A_DATA, 16'h00A5);
    expect_stream("a5", 1);
    bus_read("a5_status", A_STAT, 16'h0002);

    // Overflow with enable off, then drain 8 contiguous frames.
    @(negedge clk);
    bus_write(A_CTRL, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      bytes[i] = 8'h10 + 8'(i * 17);
      bus_write(A_DATA, 16'(bytes[i]));
    end
    bus_read("ovf_status", A_STAT, 16'h0089);
    check("ovf_idle_tx", 16'(tx), 16'h1);
    @(negedge clk);
    bus_write(A_CTRL, 16'h0005);
    bus_read("ovf_cleared", A_STAT, 16'h0081);
    expect_stream("burst", 8);
    bus_read("burst_status", A_STAT, 16'h0002);
    expect_quiet("burst_no_ninth", 3 * NB * C);

    // Reset during third data bit of first of two frames.
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_DATA, 16'h005A);
    bus_write(A_DATA, 16'h003C);
    bus_write(A_CTRL, 16'h0001);
    repeat (2 + 3 * C) @(negedge clk);
    check("rst_mid_bit2", 16'(tx), 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_tx", 16'(tx), 16'h1);
    check("rst_mid_busy", 16'(tx_busy), 16'h0);
    bus_read("rst_mid_status", A_STAT, 16'h0002);
    @(negedge clk);
    rst = 1'b1;
    expect_quiet("rst_mid_quiet", 3 * NB * C);
    bus_read("rst_mid_ctrl", A_CTRL, 16'h0001);

    // Flush mid-frame with three more bytes queued.
    @(negedge clk);
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_DATA, 16'h0011);
    bus_write(A_DATA, 16'h0022);
    bus_write(A_DATA, 16'h0033);
    bus_write(A_DATA, 16'h0044);
    bus_write(A_CTRL, 16'h0001);
    repeat (10) @(negedge clk);
    bus_write(A_CTRL, 16'h0003);
    bus_read("flush_status", A_STAT, 16'h0006);
    repeat (NB * C - 11) @(negedge clk);
    check("flush_last_busy", 16'(tx_busy), 16'h1);
    @(negedge clk);
    check("flush_done_busy", 16'(tx_busy), 16'h0);
    check("flush_done_tx", 16'(tx), 16'h1);
    expect_quiet("flush_quiet", 2 * NB * C);
    bus_read("flush_end_status", A_STAT, 16'h0002);
    bus_read("flush_ctrl", A_CTRL, 16'h0001);

    // 0x07: parity bit 1 when parity is built in; frame length via end-of-busy.
    @(negedge clk);
    bytes[0] = 8'h07;
    bus_write(A_DATA, 16'h0007);
    expect_stream("p07", 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
